// File: rtl/calc_pkg.sv
// Shared calculator definitions: multiplier FSM states and the default datapath width.
package calc_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

    localparam int CALC_N = 32;

endpackage

// File: rtl/seq_shift_add_mult.sv
// Radix-2 sequential shift-and-add multiplier, one multiplier bit per cycle, N-cycle latency.
// MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_shift_add_mult
    import calc_pkg::*;
#(
    parameter int N = CALC_N
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           Start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           Busy,
    output logic           Done,
    output logic [2*N-1:0] Product
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    mult_state_t    state_q;
    logic [2*N-1:0] acc_q;
    logic [2*N-1:0] mcand_q;
    logic [2*N-1:0] product_q;
    logic [N-1:0]   mplier_q;
    logic [CW-1:0]  count_q;
    logic           busy_q;
    logic           done_q;

    logic [2*N-1:0] acc_d;
    logic [N-1:0]   mplier_d;
    logic           last_d;

    always_comb begin
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_d = mplier_q >> 1;
`ifdef MULT_EARLY_TERM_EN
        // No set bits left means further iterations cannot change acc.
        last_d   = (count_q == CW'(N - 1)) || (mplier_d == '0);
`else
        last_d   = (count_q == CW'(N - 1));
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (Start) begin
                        state_q  <= RUN;
                        acc_q    <= '0;
                        mcand_q  <= {{N{1'b0}}, A};
                        mplier_q <= B;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end else begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_d;
                    count_q  <= count_q + 1'b1;
                    if (last_d) begin
                        state_q   <= DONE;
                        product_q <= acc_d;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult with a product scoreboard; honours MULT_EARLY_TERM_EN.
module tb_seq_shift_add_mult;

    logic        Clk   = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [31:0] A     = '0;
    logic [31:0] B     = '0;
    logic        Busy;
    logic        Done;
    logic [63:0] Product;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] exp_q[$];

    seq_shift_add_mult #(.N(32)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int exp_lat(input logic [31:0] b);
        int l;
`ifdef MULT_EARLY_TERM_EN
        l = 1;
        for (int i = 0; i < 32; i++)
            if (b[i]) l = i + 1;
`else
        l = 32;
`endif
        return l;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        A     = a;
        B     = b;
        Start = 1'b1;
        step();
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        exp_q.push_back({32'b0, a} * {32'b0, b});
    endtask

    // Cycles are counted from the most recent sampling point; bounded.
    task automatic wait_done(output int cyc, output logic busy_ok);
        cyc     = 0;
        busy_ok = 1'b1;
        while (cyc < 100) begin
            step();
            cyc++;
            if (Done) break;
            if (!Busy) busy_ok = 1'b0;
        end
    endtask

    task automatic score(input string tag);
        logic [63:0] e;
        check({tag, "_done"}, Done, 1'b1);
        check({tag, "_busy_at_done"}, Busy, 1'b0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        check({tag, "_product"}, Product, e);
    endtask

    initial begin
        int   cyc;
        int   rp;
        logic bok;
        logic saw;

        // Reset state
        repeat (2) step();
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_product", Product, 64'd0);
        Rst_n = 1'b1;
        step();

        // 10 x 30
        accept(32'd10, 32'd30);
        check("t1_busy_c0", Busy, 1'b1);
        wait_done(cyc, bok);
        check("t1_latency", 64'(cyc), 64'(exp_lat(32'd30)));
        check("t1_busy_span", bok, 1'b1);
        score("t1");
        step();
        check("t1_done_pulse", Done, 1'b0);
        check("t1_product_hold", Product, 64'd300);

        // Max operands
        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, bok);
        check("t2_latency", 64'(cyc), 64'(exp_lat(32'hFFFF_FFFF)));
        score("t2");
        check("t2_literal", Product, 64'hFFFF_FFFE_0000_0001);

        // Zero multiplier
        accept(32'h1234, 32'd0);
        wait_done(cyc, bok);
        check("t3_latency", 64'(cyc), 64'(exp_lat(32'd0)));
        score("t3");

        // Single high multiplier bit
        accept(32'd5, 32'h8);
        wait_done(cyc, bok);
        check("t4_latency", 64'(cyc), 64'(exp_lat(32'h8)));
        score("t4");

        // Start re-pulsed mid-run must be ignored
        rp = (exp_lat(32'd30) > 12) ? 10 : 2;
        accept(32'd10, 32'd30);
        repeat (rp - 1) step();
        A     = 32'd7;
        B     = 32'd9;
        Start = 1'b1;
        step();
        Start = 1'b0;
        wait_done(cyc, bok);
        check("t5_latency", 64'(rp + cyc), 64'(exp_lat(32'd30)));
        score("t5");
        step();
        check("t5_no_restart", Busy, 1'b0);

        // Reset mid-run abandons the operation
        accept(32'd5, 32'hFFFF_FFFF);
        repeat (14) step();
        Rst_n = 1'b0;
        step();
        check("t6_busy", Busy, 1'b0);
        check("t6_done", Done, 1'b0);
        check("t6_product", Product, 64'd0);
        Rst_n = 1'b1;
        exp_q.delete();
        saw = 1'b0;
        repeat (40) begin
            step();
            if (Done) saw = 1'b1;
        end
        check("t6_no_done", saw, 1'b0);

        // Start held high: back-to-back operations
        A     = 32'd3;
        B     = 32'd4;
        Start = 1'b1;
        step();
        exp_q.push_back(64'd12);
        A     = 32'd6;
        B     = 32'd7;
        wait_done(cyc, bok);
        check("t7a_latency", 64'(cyc), 64'(exp_lat(32'd4)));
        score("t7a");
        step();
        exp_q.push_back(64'd42);
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        check("t7_reaccept_busy", Busy, 1'b1);
        wait_done(cyc, bok);
        check("t7_gap", 64'(cyc + 1), 64'(exp_lat(32'd7) + 1));
        score("t7b");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
